pipe_stage_buf: RTL and testbench



---
 rtl/pipe_pkg.sv | 68 ++++++
 rtl/pipe_ring.sv | 75 +++++++
 rtl/pipe_stage_buf.sv | 66 ++++++
 tb/tb_pipe_stage_buf.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage payload structs, widths, helpers.
// Exports PAYLOAD_W_DEF, word_t, aluop_t, *_t stage bundles, HALT_BIT_*.
package pipe_pkg;

    localparam int PAYLOAD_W_DEF = 128;
    localparam int XLEN          = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_PASS
    } aluop_t;

    // halt sits in the LSB of every bundle
    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  halt;
    } if_id_t;

    typedef struct packed {
        word_t      pc;
        word_t      rs1_val;
        word_t      rs2_val;
        word_t      imm;
        aluop_t     aluop;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       halt;
    } id_ex_t;

    typedef struct packed {
        word_t      alu_res;
        word_t      store_val;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       halt;
    } ex_mem_t;

    typedef struct packed {
        word_t      wb_val;
        logic [4:0] rd;
        logic       reg_we;
        logic       halt;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    localparam int HALT_BIT_IF_ID  = 0;
    localparam int HALT_BIT_ID_EX  = 0;
    localparam int HALT_BIT_EX_MEM = 0;
    localparam int HALT_BIT_MEM_WB = 0;

    // pointer width; a single-entry ring still needs a 1-bit index
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_ring.sv
// In-order circular store: DEPTH x W entries with rp/wp/count.
// Ports: clk, rst, clr, push, pop, wdata in; head, count out.
module pipe_ring
    import pipe_pkg::*;
#(
    parameter  int W        = PAYLOAD_W_DEF,
    parameter  int DEPTH    = 2,
    parameter  bit ZERO_CLR = 1'b1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int             PW   = ptr_w(DEPTH);
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // explicit wrap so DEPTH=3 goes 2 -> 0
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (pop)
            rp_d = inc(rp_q);
        if (push)
            wp_d = inc(wp_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (clr) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            if (ZERO_CLR)
                for (int i = 0; i < DEPTH; i++)
                    mem_q[i] <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            if (push)
                mem_q[wp_q] <= wdata;
        end
    end

    assign head  = mem_q[rp_q];
    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic stage buffer: valid/ready both sides, freeze, flush, halt.
// Ports: CLK, RST, in_*, out_*, freeze, flush, count, halt_seen.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter  int PAYLOAD_W     = PAYLOAD_W_DEF,
    parameter  int DEPTH         = 2,
    parameter  int ZERO_ON_FLUSH = 1,
    parameter  int HALT_BIT      = 0,
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 freeze,
    input  logic                 flush,
    output logic [CW-1:0]        count,
    output logic                 halt_seen
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                 push, pop;
    logic                 halt_q, halt_d;
    logic [PAYLOAD_W-1:0] head;

    // reset, flush and freeze all block both handshakes
    assign in_ready  = (count < FULL) & ~freeze & ~flush & ~RST;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~freeze & ~flush & ~RST;

    pipe_ring #(
        .W        (PAYLOAD_W),
        .DEPTH    (DEPTH),
        .ZERO_CLR (ZERO_ON_FLUSH != 0)
    ) u_ring (
        .clk   (CLK),
        .rst   (RST),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (head),
        .count (count)
    );

    assign out_data = (out_valid || ZERO_ON_FLUSH == 0) ? head : '0;

    assign halt_d = halt_q | (push & in_data[HALT_BIT]);

    always_ff @(posedge CLK) begin
        if (RST)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end

    assign halt_seen = halt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench: DEPTH 1/2/3 instances on shared stimulus vs queue model.
// Literal pins at key points anchor the model.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst, iv, ordy, frz, fls;
    logic [15:0] id;

    logic        ir [3];
    logic        ov [3];
    logic        hs [3];
    logic [15:0] od [3];
    logic [0:0]  c1;
    logic [1:0]  c2, c3;
    int          cnt [3];

    int checks = 0;
    int fails  = 0;
    bit en     = 1'b0;

    localparam int D  [3] = '{1, 2, 3};
    localparam int HB [3] = '{0, 15, 0};

    logic [15:0] mq  [3][4];
    int          mn  [3];
    logic        mhs [3];

    always #5 clk = ~clk;

    pipe_stage_buf #(.PAYLOAD_W(16), .DEPTH(1), .ZERO_ON_FLUSH(1), .HALT_BIT(0)) u_d1 (
        .CLK(clk), .RST(rst), .in_valid(iv), .in_ready(ir[0]), .in_data(id),
        .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]),
        .freeze(frz), .flush(fls), .count(c1), .halt_seen(hs[0]));

    pipe_stage_buf #(.PAYLOAD_W(16), .DEPTH(2), .ZERO_ON_FLUSH(1), .HALT_BIT(15)) u_d2 (
        .CLK(clk), .RST(rst), .in_valid(iv), .in_ready(ir[1]), .in_data(id),
        .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]),
        .freeze(frz), .flush(fls), .count(c2), .halt_seen(hs[1]));

    pipe_stage_buf #(.PAYLOAD_W(16), .DEPTH(3), .ZERO_ON_FLUSH(1), .HALT_BIT(0)) u_d3 (
        .CLK(clk), .RST(rst), .in_valid(iv), .in_ready(ir[2]), .in_data(id),
        .out_valid(ov[2]), .out_ready(ordy), .out_data(od[2]),
        .freeze(frz), .flush(fls), .count(c3), .halt_seen(hs[2]));

    always_comb begin
        cnt[0] = int'(c1);
        cnt[1] = int'(c2);
        cnt[2] = int'(c3);
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut=D%0d got=0x%0h want=0x%0h t=%0t",
                     nm, D[k], act, exp, $time);
        end
    endtask

    // FIFO semantics as a shifting list of accepted beats
    task automatic model_step();
        bit acc, pp;
        for (int k = 0; k < 3; k++) begin
            acc = iv && !rst && !frz && !fls && (mn[k] < D[k]);
            pp  = (mn[k] > 0) && ordy && !rst && !frz && !fls;
            if (rst) begin
                mn[k]  = 0;
                mhs[k] = 1'b0;
            end else if (fls) begin
                mn[k] = 0;
            end else begin
                if (pp) begin
                    for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
                    mn[k]--;
                end
                if (acc) begin
                    mq[k][mn[k]] = id;
                    mn[k]++;
                    if (id[HB[k]]) mhs[k] = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (en) begin
            for (int k = 0; k < 3; k++) begin
                chk("out_valid", k, 32'(ov[k]), 32'(mn[k] > 0));
                chk("out_data", k, 32'(od[k]),
                    (mn[k] > 0) ? 32'(mq[k][0]) : 32'h0);
                chk("count", k, 32'(cnt[k]), 32'(mn[k]));
                chk("halt_seen", k, 32'(hs[k]), 32'(mhs[k]));
                chk("in_ready", k, 32'(ir[k]),
                    32'((mn[k] < D[k]) && !frz && !fls && !rst));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; frz = 1'b0; fls = 1'b0; id = '0;
        step();
        en = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_rst_count", 1, 32'(c2), 0);
        chk("lit_rst_data", 1, 32'(od[1]), 0);
        chk("lit_rst_halt", 1, 32'(hs[1]), 0);

        // stream 0x11..0x15 with out_ready held high
        ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iv = 1'b1; id = 16'h11 + 16'(i);
            step();
            chk("lit_stream_data", 1, 32'(od[1]), 32'h11 + 32'(i));
            chk("lit_stream_count", 1, 32'(c2), 1);
        end
        iv = 1'b0;
        step();
        step();

        // backpressure: A, B taken, C refused until a slot frees
        ordy = 1'b0; iv = 1'b1;
        id = 16'h000A; step();
        id = 16'h000B; step();
        id = 16'h000C; step();
        chk("lit_bp_count", 1, 32'(c2), 2);
        chk("lit_bp_head", 1, 32'(od[1]), 32'hA);
        ordy = 1'b1;
        step();
        chk("lit_bp_b", 1, 32'(od[1]), 32'hB);
        step();
        chk("lit_bp_c", 1, 32'(od[1]), 32'hC);
        iv = 1'b0;
        step();
        chk("lit_bp_empty", 1, 32'(c2), 0);
        step();

        // freeze holds head 0x33
        ordy = 1'b0; iv = 1'b1; id = 16'h0033;
        step();
        frz = 1'b1; ordy = 1'b1; id = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_frz_data", 1, 32'(od[1]), 32'h33);
            chk("lit_frz_count", 1, 32'(c2), 1);
        end
        frz = 1'b0; iv = 1'b0;
        step();
        chk("lit_frz_release", 1, 32'(c2), 0);
        iv = 1'b1;
        step();
        chk("lit_frz_resume", 1, 32'(od[1]), 32'h77);
        iv = 1'b0;
        step();
        step();

        // flush beats freeze and both handshakes
        ordy = 1'b0; iv = 1'b1;
        id = 16'h0055; step();
        id = 16'h0066; step();
        chk("lit_fl_pre", 1, 32'(c2), 2);
        fls = 1'b1; frz = 1'b1; ordy = 1'b1; id = 16'h0044;
        step();
        chk("lit_fl_count", 1, 32'(c2), 0);
        chk("lit_fl_valid", 1, 32'(ov[1]), 0);
        chk("lit_fl_data", 1, 32'(od[1]), 0);
        fls = 1'b0; frz = 1'b0; iv = 1'b0;
        step();
        chk("lit_fl_drop", 1, 32'(ov[1]), 0);

        // halt: sticky across flush, cleared by reset
        chk("lit_halt_pre", 1, 32'(hs[1]), 0);
        iv = 1'b1; id = 16'h8001;
        step();
        chk("lit_halt_set", 1, 32'(hs[1]), 1);
        iv = 1'b0; fls = 1'b1;
        step();
        fls = 1'b0;
        chk("lit_halt_flush", 1, 32'(hs[1]), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_halt_rst", 1, 32'(hs[1]), 0);
        step();

        // continuous stream: DEPTH=1 alternates
        ordy = 1'b1; iv = 1'b1;
        id = 16'h0020;
        step();
        chk("lit_d1_c0", 0, 32'(c1), 1);
        chk("lit_d1_d0", 0, 32'(od[0]), 32'h20);
        step();
        chk("lit_d1_c1", 0, 32'(c1), 0);
        id = 16'h0022;
        step();
        chk("lit_d1_c2", 0, 32'(c1), 1);
        chk("lit_d1_d2", 0, 32'(od[0]), 32'h22);
        step();
        chk("lit_d1_c3", 0, 32'(c1), 0);
        iv = 1'b0;
        step();
        step();

        // DEPTH=3: offset pointers by one, fill, drain across the wrap
        iv = 1'b1; id = 16'h0030;
        step();
        iv = 1'b0;
        step();
        ordy = 1'b0; iv = 1'b1;
        id = 16'h0032; step();
        id = 16'h0034; step();
        id = 16'h0036; step();
        id = 16'h0038; step();
        chk("lit_d3_full", 2, 32'(c3), 3);
        chk("lit_d3_h0", 2, 32'(od[2]), 32'h32);
        iv = 1'b0; ordy = 1'b1;
        step();
        chk("lit_d3_h1", 2, 32'(od[2]), 32'h34);
        step();
        chk("lit_d3_h2", 2, 32'(od[2]), 32'h36);
        step();
        chk("lit_d3_empty", 2, 32'(c3), 0);
        step();
        step();

        en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
